spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master frame engine: accepts one {op,data} command at a time and sends it as an
// 11-bit-time frame on SS_n/MOSI, optionally followed by a turnaround and an 8-bit MISO read.
module spi_master_ctrl #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  // state  | meaning
  // IDLE   | SS_n high, waiting for a command
  // START  | SS_n low, MOSI carries the read/write selector (op[1])
  // SHIFT  | 10 frame bits {op,data}, MSB first
  // TURN   | RD_DATA only: RD_LATENCY cycles before the slave answers
  // READ   | 8 MISO samples, MSB first
  // GAP_ST | SS_n high for GAP cycles before the next frame
  typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, READ, GAP_ST} state_t;

  localparam logic [3:0] C_SHIFT_LAST = 4'd9;
  localparam logic [3:0] C_READ_LAST  = 4'd7;
  localparam logic [3:0] C_TURN_LAST  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] C_GAP_LAST   = 4'(GAP - 1);
  localparam logic [1:0] C_OP_RD_DATA = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [9:0] r_frame;
  logic [9:0] w_frame_nxt;
  logic [6:0] r_shift;
  logic [7:0] r_rsp_data;
  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic       r_busy;
  logic       r_ss_n;
  logic       r_mosi;
  logic       w_accept;
  logic       w_cnt_done;
  logic       w_ss_n_nxt;
  logic       w_mosi_nxt;

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_cnt_done = (r_cnt == 4'd0);

  // Every phase timer counts down to zero; the terminal count moves to the next phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = r_frame;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_frame_nxt = {cmd_op, cmd_data};
          w_cnt_nxt   = 4'd0;
        end
      end
      START: begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = C_SHIFT_LAST;
      end
      SHIFT: begin
        if (!w_cnt_done) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (r_frame[9:8] == C_OP_RD_DATA) begin
          w_state_nxt = TURN;
          w_cnt_nxt   = C_TURN_LAST;
        end else begin
          w_state_nxt = GAP_ST;
          w_cnt_nxt   = C_GAP_LAST;
        end
      end
      TURN: begin
        if (!w_cnt_done) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = READ;
          w_cnt_nxt   = C_READ_LAST;
        end
      end
      READ: begin
        if (!w_cnt_done) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = GAP_ST;
          w_cnt_nxt   = C_GAP_LAST;
        end
      end
      GAP_ST: begin
        if (!w_cnt_done) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Pin values are decoded from the next state so SS_n/MOSI leave a flop in step with the state.
  always_comb begin
    w_ss_n_nxt = 1'b1;
    w_mosi_nxt = 1'b0;
    case (w_state_nxt)
      START: begin
        w_ss_n_nxt = 1'b0;
        w_mosi_nxt = w_frame_nxt[9];
      end
      SHIFT: begin
        w_ss_n_nxt = 1'b0;
        w_mosi_nxt = w_frame_nxt[w_cnt_nxt];
      end
      TURN, READ: begin
        w_ss_n_nxt = 1'b0;
      end
      default: begin
        w_ss_n_nxt = 1'b1;
        w_mosi_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_frame     <= 10'd0;
      r_shift     <= 7'd0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame     <= w_frame_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_ss_n      <= w_ss_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_rsp_valid <= 1'b0;
      if (r_state == READ) begin
        r_shift <= {r_shift[5:0], MISO};
        if (w_cnt_done) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= {r_shift, MISO};
        end
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a register-file SPI slave model on the pins plus a
// command-level reference model that predicts frames, read data and handshake timing.
module tb_spi_master_ctrl;

  localparam int L = 2;
  localparam int G = 2;

  typedef struct {logic [1:0] op; logic [7:0] data; bit b2b;} exp_t;
  typedef struct {logic [1:0] op; logic [7:0] data; int cyc;} acc_t;
  typedef struct {int len; logic [10:0] bits; bit tail_nz; int hi;} frame_t;
  typedef struct {logic [7:0] data; int cyc;} rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  spi_master_ctrl #(.RD_LATENCY(L), .GAP(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  exp_t   exp_q[$];
  acc_t   acc_q[$];
  frame_t frame_q[$];
  rsp_t   rsp_q[$];
  int     ai = 0;
  int     fi = 0;
  int     ri = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] ref_addr = 8'h00;
  logic [7:0] ref_last = 8'h00;
  bit         prev_hold = 0;

  // handshake and response monitors
  acc_t m_acc;
  rsp_t m_rsp;
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      m_acc.op = cmd_op; m_acc.data = cmd_data; m_acc.cyc = cyc;
      acc_q.push_back(m_acc);
    end
    if (rsp_valid) begin
      m_rsp.data = rsp_data; m_rsp.cyc = cyc;
      rsp_q.push_back(m_rsp);
    end
  end

  // slave: decodes 11 MOSI bit-times, keeps an address pointer and memory, answers RD_DATA
  logic [7:0]  s_mem [256];
  bit          s_init = 0;
  int          s_len = 0;
  int          s_hi = 0;
  logic [10:0] s_bits = '0;
  bit          s_tail = 0;
  bit          s_rd = 0;
  logic [7:0]  s_addr = 8'h00;
  logic [7:0]  s_rdbyte = 8'h00;
  bit          idle_mosi_nz = 0;
  frame_t      s_fr;
  always @(negedge clk) begin
    if (!s_init) begin
      for (int i = 0; i < 256; i++) s_mem[i] = 8'(i * 7 + 3);
      s_init = 1;
    end
    MISO = 1'($urandom_range(0, 1));
    if (!SS_n) begin
      if (s_len < 11) s_bits = {s_bits[9:0], MOSI};
      else if (MOSI) s_tail = 1;
      if (s_len == 10) begin
        case (s_bits[9:8])
          2'b00, 2'b10: s_addr = s_bits[7:0];
          2'b01:        s_mem[s_addr] = s_bits[7:0];
          default: begin s_rd = 1; s_rdbyte = s_mem[s_addr]; end
        endcase
      end
      if (s_rd && s_len >= 11 + L && s_len < 19 + L) begin
        MISO = s_rdbyte[7];
        s_rdbyte = {s_rdbyte[6:0], 1'b0};
      end
      s_len++;
    end else begin
      if (s_len > 0) begin
        s_fr.len = s_len; s_fr.bits = s_bits; s_fr.tail_nz = s_tail; s_fr.hi = s_hi;
        frame_q.push_back(s_fr);
        s_hi = 0;
      end
      if (MOSI) idle_mosi_nz = 1;
      s_hi++;
      s_len = 0; s_tail = 0; s_rd = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input bit hold);
    int t;
    exp_t e;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 300);
    check("accept_wait", 32'(t < 300), 1);
    @(posedge clk); #1;
    e.op = op; e.data = d; e.b2b = prev_hold;
    exp_q.push_back(e);
    prev_hold = hold;
    if (!hold) begin
      cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~d;
    end
  endtask

  task automatic verify();
    int t;
    int prev_cyc;
    logic [1:0] prev_op;
    exp_t e;
    acc_t a;
    frame_t f;
    rsp_t r;
    prev_cyc = 0; prev_op = 2'b00; t = 0;
    repeat (2) @(negedge clk);
    while ((busy || !SS_n) && t < 500) begin @(negedge clk); t++; end
    check("idle_wait", 32'(t < 500), 1);
    repeat (3) @(negedge clk);
    check("accept_count", acc_q.size() - ai, exp_q.size());
    check("frame_count", frame_q.size() - fi, exp_q.size());
    while (exp_q.size() > 0 && ai < acc_q.size() && fi < frame_q.size()) begin
      e = exp_q.pop_front();
      a = acc_q[ai]; ai++;
      f = frame_q[fi]; fi++;
      check("accept_cmd", 32'({a.op, a.data}), 32'({e.op, e.data}));
      check("mosi_bits", 32'(f.bits), 32'({e.op[1], e.op, e.data}));
      check("ss_low_len", f.len, (e.op == 2'b11) ? 19 + L : 11);
      check("mosi_tail_zero", 32'(f.tail_nz), 0);
      check("gap_min", 32'(f.hi >= G), 1);
      if (e.b2b) check("accept_spacing", a.cyc - prev_cyc, (prev_op == 2'b11) ? 20 + L + G : 12 + G);
      case (e.op)
        2'b00, 2'b10: ref_addr = e.data;
        2'b01:        ref_mem[ref_addr] = e.data;
        default: begin
          check("rsp_present", 32'(ri < rsp_q.size()), 1);
          if (ri < rsp_q.size()) begin
            r = rsp_q[ri]; ri++;
            check("rsp_data", 32'(r.data), 32'(ref_mem[ref_addr]));
            check("rsp_latency", r.cyc - a.cyc, 20 + L);
          end
          ref_last = ref_mem[ref_addr];
        end
      endcase
      prev_cyc = a.cyc; prev_op = e.op;
    end
    exp_q.delete();
    check("rsp_extra", rsp_q.size() - ri, 0);
    check("rsp_hold", 32'(rsp_data), 32'(ref_last));
    check("busy_idle", 32'(busy), 0);
    check("mosi_idle_zero", 32'(idle_mosi_nz), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] r_op;
  logic [7:0] r_d;
  bit         r_h;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_ss_n", 32'(SS_n), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 1);
    @(posedge clk); #1;

    // WR_ADDR A5 single frame
    issue(2'b00, 8'hA5, 0);
    verify();

    // write 3C to 10, read it back
    issue(2'b00, 8'h10, 0);
    issue(2'b01, 8'h3C, 0);
    issue(2'b10, 8'h10, 0);
    issue(2'b11, 8'h5A, 0);
    verify();
    check("read_3c", 32'(rsp_data), 32'h3C);

    // MISO pattern 1,0,1,1,0,0,1,0
    issue(2'b00, 8'h20, 0);
    issue(2'b01, 8'hB2, 0);
    issue(2'b10, 8'h20, 0);
    issue(2'b11, 8'h00, 0);
    verify();
    check("read_b2", 32'(rsp_data), 32'hB2);

    // data 00 accepted, then cmd_data changes to FF
    issue(2'b00, 8'h00, 0);
    verify();

    // four back-to-back commands with cmd_valid held
    issue(2'b01, 8'h11, 1);
    issue(2'b00, 8'h22, 1);
    issue(2'b11, 8'h33, 1);
    issue(2'b01, 8'h44, 0);
    verify();

    // reset during SHIFT bit 5 of an RD_DATA
    issue(2'b11, 8'h00, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_in_frame", 32'(SS_n), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ss_n", 32'(SS_n), 1);
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_mosi", 32'(MOSI), 0);
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 1);
    check("abort_frame_seen", 32'(fi < frame_q.size()), 1);
    if (fi < frame_q.size()) check("abort_len", frame_q[fi].len, 6);
    repeat (30) @(negedge clk);
    check("abort_no_rsp", rsp_q.size() - ri, 0);
    void'(exp_q.pop_back());
    ai = acc_q.size();
    fi = frame_q.size();
    ref_last = 8'h00;
    prev_hold = 0;
    @(posedge clk); #1;
    issue(2'b10, 8'h20, 0);
    issue(2'b11, 8'hC3, 0);
    verify();
    check("post_abort_read", 32'(rsp_data), 32'hB2);

    // randomized command streams
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r_op = 2'($urandom_range(0, 3));
        r_d  = 8'($urandom_range(0, 255));
        r_h  = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        issue(r_op, r_d, r_h);
        if (!r_h) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      verify();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
